// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative unsigned shift-add multiplier with start/busy/done handshake
//
// Purpose:
//   Multiplies two unsigned WIDTH-bit operands into a 2*WIDTH-bit product,
//   retiring one multiplier bit per clock. The operation always takes exactly
//   WIDTH iterations, whatever the operand values.
//
// Ports:
//   clk    in   1        rising-edge system clock
//   rst_n  in   1        asynchronous active-low reset; aborts any multiply
//   start  in   1        request; accepted in IDLE or in the DONE cycle
//   A      in   WIDTH    multiplicand, captured when start is accepted
//   B      in   WIDTH    multiplier, captured when start is accepted
//   busy   out  1        high while iterations are running
//   done   out  1        one-cycle pulse when P has just been updated
//   P      out  2*WIDTH  last completed product, held until the next completion

module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          stateNext;

    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   count;

    logic            loadOps;
    logic            stepOp;
    logic            lastIter;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   accSum;

    // The final iteration's sum goes straight into P, so the product is
    // available on the same edge that moves the FSM to DONE.
    assign lastIter = (count == CW'(WIDTH - 1));
    assign addend   = mplier[0] ? mcand : '0;
    assign accSum   = acc + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        loadOps   = 1'b0;
        stepOp    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    loadOps   = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                // start is deliberately not looked at here.
                stepOp = 1'b1;
                if (lastIter) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                // Accepting start here gives back-to-back operation with
                // one result every WIDTH+1 cycles.
                if (start) begin
                    loadOps   = 1'b1;
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            P      <= '0;
        end else if (loadOps) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            count  <= '0;
        end else if (stepOp) begin
            acc    <= accSum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (lastIter) begin
                P <= accSum;
            end
        end
    end

    // Status outputs come from flops loaded with the decoded next state, so
    // they change on the same edge as the state and never see start/A/B
    // combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (stateNext == RUN);
            done <= (stateNext == DONE);
        end
    end

endmodule
